// File: rtl/sram_space_tracker_if.sv
// Clock and active-low asynchronous reset bundle shared by the SRAM datapath blocks.
interface system_if;
  logic clk;
  logic rst;

  modport slave  (input clk, input rst);
  modport master (output clk, output rst);
endinterface

// File: rtl/sram_space_tracker.sv
// Free-page bookkeeping for the shared SRAM banks: grants/refuses per-port page
// allocations, accepts releases, answers bank lookups, and re-initialises on request.
module sram_space_tracker #(
  parameter int unsigned NPORT     = 16,
  parameter int unsigned NBANK     = 32,
  parameter int unsigned SPACE_MAX = 2047,
  localparam int unsigned BW = $clog2(NBANK),
  localparam int unsigned CW = $clog2(SPACE_MAX + 1)
) (
  system_if.slave                 sys_if,
  input  logic [NPORT-1:0]        port_align,
  input  logic [NPORT-1:0][BW-1:0] port_sram,
  input  logic                    rel_valid,
  input  logic [BW-1:0]           rel_bank,
  input  logic [BW-1:0]           find_0,
  input  logic [BW-1:0]           find_1,
  input  logic [BW-1:0]           find_2,
  input  logic [BW-1:0]           find_3,
  output logic [CW-1:0]           space_0,
  output logic [CW-1:0]           space_1,
  output logic [CW-1:0]           space_2,
  output logic [CW-1:0]           space_3,
  output logic [NPORT-1:0]        alloc_grant,
  output logic [NPORT-1:0]        alloc_fail,
  input  logic                    init_req,
  output logic                    busy,
  output logic                    ovf_err,
  output logic                    rel_drop
);

  typedef enum logic {RUN, INIT} state_t;

  state_t        state;
  logic [BW-1:0] sweep;
  logic [CW-1:0] free    [NBANK];
  logic [CW-1:0] free_nx [NBANK];
  logic [CW-1:0] gcnt    [NBANK];
  logic [NPORT-1:0] grant_nx;
  logic [NPORT-1:0] fail_nx;
  logic [CW:0]   nx;

  // Ports are walked in ascending index so lower ports win a contended bank;
  // gcnt tracks pages already handed out per bank within this cycle.
  always_comb begin
    grant_nx = '0;
    fail_nx  = '0;
    nx       = '0;
    for (int unsigned b = 0; b < NBANK; b++) begin
      gcnt[b]    = '0;
      free_nx[b] = '0;
    end
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (port_align[i]) begin
        if (gcnt[port_sram[i]] < free[port_sram[i]]) begin
          grant_nx[i]         = 1'b1;
          gcnt[port_sram[i]]  = gcnt[port_sram[i]] + CW'(1);
        end else begin
          fail_nx[i] = 1'b1;
        end
      end
    end
    // Release is applied after grants (grants see the pre-release count), then capped.
    for (int unsigned b = 0; b < NBANK; b++) begin
      nx = {1'b0, free[b]} - {1'b0, gcnt[b]};
      if (rel_valid && rel_bank == BW'(b))
        nx = nx + (CW+1)'(1);
      if (nx > (CW+1)'(SPACE_MAX))
        free_nx[b] = CW'(SPACE_MAX);
      else
        free_nx[b] = nx[CW-1:0];
    end
  end

  always_ff @(posedge sys_if.clk or negedge sys_if.rst) begin
    if (!sys_if.rst) begin
      state       <= RUN;
      sweep       <= '0;
      free        <= '{default: CW'(SPACE_MAX)};
      space_0     <= CW'(SPACE_MAX);
      space_1     <= CW'(SPACE_MAX);
      space_2     <= CW'(SPACE_MAX);
      space_3     <= CW'(SPACE_MAX);
      alloc_grant <= '0;
      alloc_fail  <= '0;
      busy        <= 1'b0;
      ovf_err     <= 1'b0;
      rel_drop    <= 1'b0;
    end else begin
      space_0     <= free[find_0];
      space_1     <= free[find_1];
      space_2     <= free[find_2];
      space_3     <= free[find_3];
      alloc_grant <= '0;
      alloc_fail  <= '0;
      rel_drop    <= 1'b0;
      case (state)
        RUN: begin
          free        <= free_nx;
          alloc_grant <= grant_nx;
          alloc_fail  <= fail_nx;
          if (rel_valid && free[rel_bank] == CW'(SPACE_MAX))
            ovf_err <= 1'b1;
          if (init_req) begin
            state   <= INIT;
            busy    <= 1'b1;
            sweep   <= '0;
            ovf_err <= 1'b0;
          end
        end
        INIT: begin
          free[sweep] <= CW'(SPACE_MAX);
          alloc_fail  <= port_align;
          rel_drop    <= rel_valid;
          sweep       <= sweep + BW'(1);
          if (sweep == BW'(NBANK - 1)) begin
            state <= RUN;
            busy  <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_space_tracker.sv
// Directed bench for sram_space_tracker: reset, contention, same-cycle alloc/release,
// overflow, INIT sweep and reset during INIT, all with hand-computed expectations.
module tb_sram_space_tracker;

  system_if sys_if ();

  logic [15:0]      port_align;
  logic [15:0][4:0] port_sram;
  logic             rel_valid;
  logic [4:0]       rel_bank;
  logic [4:0]       find_0, find_1, find_2, find_3;
  logic [10:0]      space_0, space_1, space_2, space_3;
  logic [15:0]      alloc_grant, alloc_fail;
  logic             init_req, busy, ovf_err, rel_drop;

  int checks = 0;
  int errors = 0;
  int busy_cnt;

  sram_space_tracker #(.NPORT(16), .NBANK(32), .SPACE_MAX(2047)) dut (
    .sys_if      (sys_if),
    .port_align  (port_align),
    .port_sram   (port_sram),
    .rel_valid   (rel_valid),
    .rel_bank    (rel_bank),
    .find_0      (find_0),
    .find_1      (find_1),
    .find_2      (find_2),
    .find_3      (find_3),
    .space_0     (space_0),
    .space_1     (space_1),
    .space_2     (space_2),
    .space_3     (space_3),
    .alloc_grant (alloc_grant),
    .alloc_fail  (alloc_fail),
    .init_req    (init_req),
    .busy        (busy),
    .ovf_err     (ovf_err),
    .rel_drop    (rel_drop)
  );

  initial sys_if.clk = 1'b0;
  always #5 sys_if.clk = ~sys_if.clk;

  task automatic tick();
    @(posedge sys_if.clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    sys_if.rst = 1'b0;
    port_align = '0;
    port_sram  = '0;
    rel_valid  = 1'b0;
    rel_bank   = '0;
    init_req   = 1'b0;
    find_0 = 5'd0; find_1 = 5'd5; find_2 = 5'd17; find_3 = 5'd31;
    tick(); tick();
    chk("rst_space0", 32'(space_0), 32'd2047);
    chk("rst_grant", 32'(alloc_grant), 32'd0);
    chk("rst_fail", 32'(alloc_fail), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(ovf_err), 32'd0);
    chk("rst_drop", 32'(rel_drop), 32'd0);
    @(negedge sys_if.clk);
    sys_if.rst = 1'b1;
    tick();
    chk("q_space0", 32'(space_0), 32'd2047);
    chk("q_space1", 32'(space_1), 32'd2047);
    chk("q_space2", 32'(space_2), 32'd2047);
    chk("q_space3", 32'(space_3), 32'd2047);

    // Preload bank 6 to 3: 127 x 16 grants + 12 grants = 2044
    for (int i = 0; i < 16; i++) port_sram[i] = 5'd6;
    find_0 = 5'd6;
    port_align = 16'hFFFF;
    tick();
    chk("pre_grant_first", 32'(alloc_grant), 32'hFFFF);
    for (int c = 1; c < 127; c++) tick();
    chk("space_after_drain", 32'(space_0), 32'd31);
    port_align = 16'h0FFF;
    tick();
    chk("pre_grant_last", 32'(alloc_grant), 32'h0FFF);
    chk("pre_fail_last", 32'(alloc_fail), 32'h0000);
    port_align = 16'hFFFF;
    tick();
    chk("cont_space_pre", 32'(space_0), 32'd3);
    chk("cont_grant", 32'(alloc_grant), 32'h0007);
    chk("cont_fail", 32'(alloc_fail), 32'hFFF8);
    port_align = '0;
    tick();
    chk("cont_space_empty", 32'(space_0), 32'd0);
    chk("idle_grant", 32'(alloc_grant), 32'd0);

    // Alloc and release on an empty bank
    port_align = 16'h0004;
    rel_valid  = 1'b1;
    rel_bank   = 5'd6;
    tick();
    chk("ar_grant", 32'(alloc_grant), 32'd0);
    chk("ar_fail", 32'(alloc_fail), 32'h0004);
    chk("ar_space_pre", 32'(space_0), 32'd0);
    port_align = '0;
    rel_valid  = 1'b0;
    tick();
    chk("ar_space_post", 32'(space_0), 32'd1);
    chk("ar_no_ovf", 32'(ovf_err), 32'd0);

    // Release overflow on full bank 9
    rel_valid = 1'b1;
    rel_bank  = 5'd9;
    find_1    = 5'd9;
    tick();
    chk("ovf_set", 32'(ovf_err), 32'd1);
    rel_valid = 1'b0;
    tick();
    chk("ovf_sticky", 32'(ovf_err), 32'd1);
    chk("ovf_space", 32'(space_1), 32'd2047);
    find_0 = 5'd6; find_1 = 5'd6; find_2 = 5'd6; find_3 = 5'd6;
    tick();
    chk("same_q0", 32'(space_0), 32'd1);
    chk("same_q1", 32'(space_1), 32'd1);
    chk("same_q2", 32'(space_2), 32'd1);
    chk("same_q3", 32'(space_3), 32'd1);

    // Drain banks 0 and 31 to 100: 243 x 8 + 3 = 1947 each
    for (int i = 0; i < 8; i++) port_sram[i] = 5'd0;
    for (int i = 8; i < 16; i++) port_sram[i] = 5'd31;
    find_0 = 5'd0; find_1 = 5'd31;
    port_align = 16'hFFFF;
    for (int c = 0; c < 243; c++) tick();
    port_align = 16'h0707;
    tick();
    chk("drain_grant", 32'(alloc_grant), 32'h0707);
    port_align = '0;
    tick();
    chk("drain_b0", 32'(space_0), 32'd100);
    chk("drain_b31", 32'(space_1), 32'd100);

    // INIT sweep
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    chk("init_busy", 32'(busy), 32'd1);
    chk("init_ovf_clr", 32'(ovf_err), 32'd0);
    busy_cnt = 1;
    for (int j = 1; j <= 40; j++) begin
      tick();
      if (j == 6) begin
        chk("init_fail4", 32'(alloc_fail), 32'h0010);
        chk("init_grant0", 32'(alloc_grant), 32'd0);
        chk("init_drop", 32'(rel_drop), 32'd1);
        port_align = '0;
        rel_valid  = 1'b0;
        init_req   = 1'b0;
      end
      if (!busy) begin
        // First RUN cycle: port 0 requests bank 0
        port_align = 16'h0001;
        break;
      end
      busy_cnt++;
      if (j == 5) begin
        port_align = 16'h0010;
        rel_valid  = 1'b1;
        rel_bank   = 5'd3;
        init_req   = 1'b1;
      end
    end
    chk("busy_cycles", 32'(busy_cnt), 32'd32);
    tick();
    port_align = '0;
    chk("resume_grant", 32'(alloc_grant), 32'h0001);
    chk("sweep_b0", 32'(space_0), 32'd2047);
    chk("sweep_b31", 32'(space_1), 32'd2047);
    chk("sweep_ovf", 32'(ovf_err), 32'd0);
    chk("sweep_drop_idle", 32'(rel_drop), 32'd0);

    // Reset during INIT: bank 20 drained in the entry cycle, sweep aborted at cycle 10
    for (int i = 0; i < 16; i++) port_sram[i] = 5'd20;
    port_align = 16'hFFFF;
    init_req   = 1'b1;
    tick();
    port_align = '0;
    init_req   = 1'b0;
    chk("ri_grant", 32'(alloc_grant), 32'hFFFF);
    chk("ri_busy", 32'(busy), 32'd1);
    for (int c = 0; c < 10; c++) tick();
    #2;
    sys_if.rst = 1'b0;
    #1;
    chk("ri_busy_clr", 32'(busy), 32'd0);
    chk("ri_space0_rst", 32'(space_0), 32'd2047);
    @(negedge sys_if.clk);
    sys_if.rst = 1'b1;
    find_0 = 5'd20; find_1 = 5'd0; find_2 = 5'd6; find_3 = 5'd31;
    tick();
    chk("ri_b20", 32'(space_0), 32'd2047);
    chk("ri_b0", 32'(space_1), 32'd2047);
    chk("ri_b6", 32'(space_2), 32'd2047);
    chk("ri_b31", 32'(space_3), 32'd2047);
    chk("ri_busy_run", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
